score_disp_ctrl: RTL and testbench

Score/display controller for the seven-segment score path. Tracks the 4-digit BCD high score, captures the final score on game over, and decides what the 8-digit segment display shows: the "High" label plus high score, the last score, the live score, or a flashing new record. Drives the 32-bit digit word into `x7segbc` and a per-digit enable mask ANDed into the anodes.

---
 rtl/seg_ctrl_pkg.sv | 23 ++
 rtl/tick_gen.sv | 31 +++
 rtl/score_disp_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_score_disp_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_ctrl_pkg.sv
// Shared types and constants for the seven-segment score/display path.
package seg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    RECORD = 2'd2
  } disp_state_t;

  // Digit pattern that x7segbc renders as the "High" label on digits 7..4.
  localparam logic [15:0] HIGH_LABEL = 16'h1024;

  localparam logic [7:0] MASK_ALL  = 8'hFF;
  localparam logic [7:0] MASK_LOW4 = 8'h0F;
  localparam logic [7:0] MASK_NONE = 8'h00;

  // Four BCD digits, digit 0 least significant.
  function automatic logic [15:0] pack_bcd(input logic [3:0] d3, input logic [3:0] d2,
                                           input logic [3:0] d1, input logic [3:0] d0);
    return {d3, d2, d1, d0};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Restartable prescaler: one-cycle tick every TICK_DIV clocks after a restart.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Tick is decoded from the count so the consumer sees it in the same cycle
  // the count sits at its terminal value.
  assign tick = (cnt == CNT_LAST);

  // Count up from 0; restart or terminal count returns to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/score_disp_ctrl.sv
// Score/display controller: high score tracking, last-score capture and
// selection of what the 8-digit seven-segment display shows.
//
//   state  | meaning
//   IDLE   | attract loop: phase A = "High"+high score, phase B = last score
//   PLAY   | live score on the low four digits
//   RECORD | new high score, whole display flashing once per tick
import seg_ctrl_pkg::*;

module score_disp_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int FLASH_TICKS = 6,
  parameter int ALT_TICKS   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_on,
  input  logic        game_over,
  input  logic [3:0]  score0,
  input  logic [3:0]  score1,
  input  logic [3:0]  score2,
  input  logic [3:0]  score3,
  input  logic        clr_high,
  output logic [3:0]  high_score0,
  output logic [3:0]  high_score1,
  output logic [3:0]  high_score2,
  output logic [3:0]  high_score3,
  output logic [31:0] disp_word,
  output logic [7:0]  disp_mask,
  output logic        new_record
);

  localparam int TMAX = (FLASH_TICKS > ALT_TICKS) ? FLASH_TICKS : ALT_TICKS;
  localparam int TCW  = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam logic [TCW-1:0] FLASH_LAST = TCW'(FLASH_TICKS - 1);
  localparam logic [TCW-1:0] ALT_LAST   = TCW'(ALT_TICKS - 1);

  disp_state_t    state, state_d;
  logic           phase_b, phase_b_d;
  logic [TCW-1:0] tick_cnt, tick_cnt_d;
  logic [15:0]    high, high_d;
  logic [15:0]    last, last_d;
  logic [31:0]    word_d;
  logic [7:0]     mask_d;
  logic           restart;
  logic           tick;
  logic [15:0]    score;

  assign score = pack_bcd(score3, score2, score1, score0);

  assign high_score0 = high[3:0];
  assign high_score1 = high[7:4];
  assign high_score2 = high[11:8];
  assign high_score3 = high[15:12];

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  // Next state, score registers, tick bookkeeping and next display contents.
  always_comb begin
    state_d    = state;
    phase_b_d  = phase_b;
    tick_cnt_d = tick_cnt;
    // A clear in the same cycle as game over makes the compare see 0000.
    high_d     = clr_high ? 16'h0000 : high;
    last_d     = last;
    restart    = 1'b0;
    word_d     = disp_word;
    mask_d     = disp_mask;

    case (state)
      IDLE: begin
        if (game_on) begin
          state_d = PLAY;
        end else if (tick) begin
          if (tick_cnt == ALT_LAST) begin
            phase_b_d  = ~phase_b;
            tick_cnt_d = '0;
            restart    = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt + TCW'(1);
          end
        end
      end
      PLAY: begin
        if (game_over) begin
          last_d = score;
          // Digits are all <= 9, so a plain binary compare orders BCD correctly.
          if (score > high_d) begin
            high_d  = score;
            state_d = RECORD;
          end else begin
            state_d = IDLE;
          end
        end else if (!game_on) begin
          state_d = IDLE;
        end
      end
      RECORD: begin
        if (game_on) begin
          state_d = PLAY;
        end else if (tick) begin
          if (tick_cnt == FLASH_LAST) begin
            state_d = IDLE;
          end else begin
            tick_cnt_d = tick_cnt + TCW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every state entry starts a fresh tick period and IDLE always opens on phase A.
    if (state_d != state) begin
      restart    = 1'b1;
      tick_cnt_d = '0;
      phase_b_d  = 1'b0;
    end

    case (state_d)
      IDLE: begin
        if (phase_b_d) begin
          word_d = {16'h0000, last_d};
          mask_d = MASK_LOW4;
        end else begin
          word_d = {HIGH_LABEL, high_d};
          mask_d = MASK_ALL;
        end
      end
      PLAY: begin
        word_d = {16'h0000, score};
        mask_d = MASK_LOW4;
      end
      RECORD: begin
        word_d = {HIGH_LABEL, high_d};
        if (state != RECORD) begin
          mask_d = MASK_ALL;
        end else if (tick) begin
          mask_d = (disp_mask == MASK_ALL) ? MASK_NONE : MASK_ALL;
        end else begin
          mask_d = disp_mask;
        end
      end
      default: begin
        word_d = {HIGH_LABEL, 16'h0000};
        mask_d = MASK_ALL;
      end
    endcase
  end

  // State, score and display registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase_b    <= 1'b0;
      tick_cnt   <= '0;
      high       <= 16'h0000;
      last       <= 16'h0000;
      disp_word  <= {HIGH_LABEL, 16'h0000};
      disp_mask  <= MASK_ALL;
      new_record <= 1'b0;
    end else begin
      state      <= state_d;
      phase_b    <= phase_b_d;
      tick_cnt   <= tick_cnt_d;
      high       <= high_d;
      last       <= last_d;
      disp_word  <= word_d;
      disp_mask  <= mask_d;
      new_record <= (state_d == RECORD);
    end
  end

endmodule

// File: tb/tb_score_disp_ctrl.sv
// Scoreboard bench for score_disp_ctrl with a short tick period.
module tb_score_disp_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int FLASH_TICKS = 6;
  localparam int ALT_TICKS   = 4;

  logic        clk;
  logic        rst_n;
  logic        game_on;
  logic        game_over;
  logic [3:0]  score0, score1, score2, score3;
  logic        clr_high;
  logic [3:0]  high_score0, high_score1, high_score2, high_score3;
  logic [31:0] disp_word;
  logic [7:0]  disp_mask;
  logic        new_record;

  typedef struct {
    int          stamp;
    logic [31:0] word;
    logic [7:0]  mask;
    logic        rec;
    logic [15:0] high;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc;
  int    n_tests;
  int    n_fail;

  score_disp_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .FLASH_TICKS (FLASH_TICKS),
    .ALT_TICKS   (ALT_TICKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .game_on     (game_on),
    .game_over   (game_over),
    .score0      (score0),
    .score1      (score1),
    .score2      (score2),
    .score3      (score3),
    .clr_high    (clr_high),
    .high_score0 (high_score0),
    .high_score1 (high_score1),
    .high_score2 (high_score2),
    .high_score3 (high_score3),
    .disp_word   (disp_word),
    .disp_mask   (disp_mask),
    .new_record  (new_record)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: on each falling edge, check every expectation due by this cycle.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    logic [15:0] hs;
    hs = {high_score3, high_score2, high_score1, high_score0};
    while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests = n_tests + 1;
      if (e.stamp != cyc || disp_word !== e.word || disp_mask !== e.mask ||
          new_record !== e.rec || hs !== e.high) begin
        n_fail = n_fail + 1;
        $display("FAIL %s @cyc %0d (due %0d): got word=%h mask=%h rec=%b high=%h, want word=%h mask=%h rec=%b high=%h",
                 nm, cyc, e.stamp, disp_word, disp_mask, new_record, hs,
                 e.word, e.mask, e.rec, e.high);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string nm, input logic [31:0] w,
                           input logic [7:0] m, input logic r, input logic [15:0] h);
    logic [15:0] hs;
    hs = {high_score3, high_score2, high_score1, high_score0};
    n_tests = n_tests + 1;
    if (disp_word !== w || disp_mask !== m || new_record !== r || hs !== h) begin
      n_fail = n_fail + 1;
      $display("FAIL %s @cyc %0d: got word=%h mask=%h rec=%b high=%h, want word=%h mask=%h rec=%b high=%h",
               nm, cyc, disp_word, disp_mask, new_record, hs, w, m, r, h);
    end
  endtask

  task automatic expect_at(input int off, input string nm, input logic [31:0] w,
                           input logic [7:0] m, input logic r, input logic [15:0] h);
    exp_t e;
    e.stamp = cyc + off;
    e.word  = w;
    e.mask  = m;
    e.rec   = r;
    e.high  = h;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic set_score(input logic [15:0] s);
    {score3, score2, score1, score0} = s;
  endtask

  initial begin
    cyc = 0; n_tests = 0; n_fail = 0;
    rst_n = 1'b0; game_on = 1'b0; game_over = 1'b0; clr_high = 1'b0;
    set_score(16'h0000);

    // Reset values.
    step(); step();
    check_now("reset_now", 32'h1024_0000, 8'hFF, 1'b0, 16'h0000);
    expect_at(0, "reset", 32'h1024_0000, 8'hFF, 1'b0, 16'h0000);
    step();
    rst_n = 1'b1;

    // First game: live score, then a record.
    game_on = 1'b1; set_score(16'h0123);
    expect_at(1, "play_first", 32'h0000_0123, 8'h0F, 1'b0, 16'h0000);
    step();
    set_score(16'h0120);
    expect_at(1, "play_live", 32'h0000_0120, 8'h0F, 1'b0, 16'h0000);
    step();
    set_score(16'h0123);
    game_over = 1'b1; game_on = 1'b0;
    expect_at(1, "rec_entry", 32'h1024_0123, 8'hFF, 1'b1, 16'h0123);
    step();
    game_over = 1'b0;
    expect_at(3,  "rec_pre_t1", 32'h1024_0123, 8'hFF, 1'b1, 16'h0123);
    expect_at(4,  "rec_t1",     32'h1024_0123, 8'h00, 1'b1, 16'h0123);
    expect_at(8,  "rec_t2",     32'h1024_0123, 8'hFF, 1'b1, 16'h0123);
    expect_at(12, "rec_t3",     32'h1024_0123, 8'h00, 1'b1, 16'h0123);
    expect_at(16, "rec_t4",     32'h1024_0123, 8'hFF, 1'b1, 16'h0123);
    expect_at(20, "rec_t5",     32'h1024_0123, 8'h00, 1'b1, 16'h0123);
    expect_at(23, "rec_last",   32'h1024_0123, 8'h00, 1'b1, 16'h0123);
    expect_at(24, "rec_done",   32'h1024_0123, 8'hFF, 1'b0, 16'h0123);
    repeat (24) step();
    expect_at(15, "idle_a_end", 32'h1024_0123, 8'hFF, 1'b0, 16'h0123);
    expect_at(16, "idle_b_123", 32'h0000_0123, 8'h0F, 1'b0, 16'h0123);
    repeat (16) step();

    // Lower score: no record, straight to IDLE phase A.
    game_on = 1'b1; set_score(16'h0099);
    expect_at(1, "play_99", 32'h0000_0099, 8'h0F, 1'b0, 16'h0123);
    step();
    game_on = 1'b0; game_over = 1'b1;
    expect_at(1, "norec_99", 32'h1024_0123, 8'hFF, 1'b0, 16'h0123);
    step();
    game_over = 1'b0;
    expect_at(15, "idle_a_99", 32'h1024_0123, 8'hFF, 1'b0, 16'h0123);
    expect_at(16, "idle_b_99", 32'h0000_0099, 8'h0F, 1'b0, 16'h0123);
    repeat (16) step();

    // Equal score: not a record.
    game_on = 1'b1; set_score(16'h0123);
    expect_at(1, "play_eq", 32'h0000_0123, 8'h0F, 1'b0, 16'h0123);
    step();
    game_on = 1'b0; game_over = 1'b1;
    expect_at(1, "eq_norec", 32'h1024_0123, 8'hFF, 1'b0, 16'h0123);
    expect_at(2, "eq_hold",  32'h1024_0123, 8'hFF, 1'b0, 16'h0123);
    step();
    game_over = 1'b0;
    step();

    // Clear together with game over at zero score: no record.
    game_on = 1'b1; set_score(16'h0000);
    expect_at(1, "play_zero", 32'h0000_0000, 8'h0F, 1'b0, 16'h0123);
    step();
    game_on = 1'b0; game_over = 1'b1; clr_high = 1'b1;
    expect_at(1, "clr_zero", 32'h1024_0000, 8'hFF, 1'b0, 16'h0000);
    step();
    game_over = 1'b0; clr_high = 1'b0;
    step();

    // Clear together with game over at 0005: record against 0000.
    game_on = 1'b1; set_score(16'h0005);
    expect_at(1, "play_five", 32'h0000_0005, 8'h0F, 1'b0, 16'h0000);
    step();
    game_on = 1'b0; game_over = 1'b1; clr_high = 1'b1;
    expect_at(1, "clr_five", 32'h1024_0005, 8'hFF, 1'b1, 16'h0005);
    step();
    game_over = 1'b0; clr_high = 1'b0;
    expect_at(2, "rec_hold5", 32'h1024_0005, 8'hFF, 1'b1, 16'h0005);
    step(); step();

    // Abort the flash by starting a new game.
    game_on = 1'b1; set_score(16'h0042);
    expect_at(1, "abort", 32'h0000_0042, 8'h0F, 1'b0, 16'h0005);
    step();

    // Leave PLAY without game over: last stays 0005.
    game_on = 1'b0;
    expect_at(1, "early_exit", 32'h1024_0005, 8'hFF, 1'b0, 16'h0005);
    step();
    step(); step();
    // Spurious game over in IDLE with a big score.
    game_over = 1'b1; set_score(16'h0999);
    expect_at(1, "spurious", 32'h1024_0005, 8'hFF, 1'b0, 16'h0005);
    step();
    game_over = 1'b0;
    expect_at(13, "last_kept", 32'h0000_0005, 8'h0F, 1'b0, 16'h0005);
    repeat (13) step();

    // Clear alone in IDLE phase B.
    clr_high = 1'b1;
    expect_at(1, "clr_idle", 32'h0000_0005, 8'h0F, 1'b0, 16'h0000);
    step();
    clr_high = 1'b0;

    // Reset in the middle of a record flash.
    game_on = 1'b1; set_score(16'h0777);
    expect_at(1, "play_777", 32'h0000_0777, 8'h0F, 1'b0, 16'h0000);
    step();
    game_on = 1'b0; game_over = 1'b1;
    expect_at(1, "rec_777", 32'h1024_0777, 8'hFF, 1'b1, 16'h0777);
    step();
    game_over = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    check_now("rst_async", 32'h1024_0000, 8'hFF, 1'b0, 16'h0000);
    expect_at(0, "rst_mid", 32'h1024_0000, 8'hFF, 1'b0, 16'h0000);
    step();
    step();
    rst_n = 1'b1;
    expect_at(1, "recover", 32'h1024_0000, 8'hFF, 1'b0, 16'h0000);
    step();
    step(); step();

    while (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests = n_tests + 1;
      n_fail  = n_fail + 1;
      $display("FAIL %s: expectation due @cyc %0d never checked (now %0d)", nm, e.stamp, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
